// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU and its multiply/divide datapath.
// Base op codes, M-extension codes and the control FSM states.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } seq_alu_state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider on magnitudes.
// One bit per cycle; divide special cases are flagged combinationally.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             special_o,
    output logic [WIDTH-1:0] special_res_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    muldiv_op_e         op;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               neg_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_zero;
    logic               div_ovf;

    muldiv_op_e         op_q;
    logic               neg_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_sel;

    // Operand magnitudes, result sign and special-case detection at start
    always_comb begin
        op       = muldiv_op_e'(op_i);
        is_div   = op_i[2];
        neg_a    = a_i[WIDTH-1] &&
                   (op == MD_MULH || op == MD_MULHSU ||
                    op == MD_DIV  || op == MD_REM);
        neg_b    = b_i[WIDTH-1] &&
                   (op == MD_MULH || op == MD_DIV || op == MD_REM);
        mag_a    = neg_a ? -a_i : a_i;
        mag_b    = neg_b ? -b_i : b_i;
        neg_d    = (op == MD_REM) ? neg_a : (neg_a ^ neg_b);
        div_zero = (b_i == '0);
        div_ovf  = !op_i[0] && (a_i == MIN_V) && (&b_i);
        special_o     = is_div && (div_zero || div_ovf);
        special_res_o = '0;
        if (div_zero)
            special_res_o = op_i[1] ? a_i : '1;
        else if (div_ovf)
            special_res_o = op_i[1] ? '0 : MIN_V;
    end

    // One multiply or divide step and the sign-fixed final result
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_ge    = (div_shift >= {1'b0, opd_q});
        if (op_q[2])
            acc_d = {div_ge ? div_diff[WIDTH-1:0]
                            : div_shift[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        prod    = neg_q ? -acc_d : acc_d;
        div_sel = op_q[1] ? acc_d[2*WIDTH-1:WIDTH]
                          : acc_d[WIDTH-1:0];
        if (op_q[2])
            res_o = neg_q ? -div_sel : div_sel;
        else if (op_q == MD_MUL)
            res_o = prod[WIDTH-1:0];
        else
            res_o = prod[2*WIDTH-1:WIDTH];
        done_o = busy_q && (cnt_q == LAST);
    end

    // Latch operands on start, then iterate until the counter wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            opd_q  <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            op_q   <= op;
            neg_q  <= neg_d;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            opd_q  <= is_div ? mag_b : mag_a;
            acc_q  <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle base ops plus iterative RV32M ops.
// Valid/ready on both sides; in_ready is low while busy or holding a result.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [OP_W-1:0]  operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    seq_alu_state_e   state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   base_res;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_load;
    logic               md_start;
    logic               md_special;
    logic [WIDTH-1:0]   md_special_res;
    logic               md_done;
    logic [WIDTH-1:0]   md_res;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign shamt     = operand_b[SHAMT_W-1:0];
    assign md_start  = in_ready && in_valid &&
                       operation[4] && !md_special;

    // Single-cycle base operations; unknown codes pass operand_a
    always_comb begin
        case (operation[3:0])
            OP_ADD:  base_res = operand_a + operand_b;
            OP_SUB:  base_res = operand_a - operand_b;
            OP_SLL:  base_res = operand_a << shamt;
            OP_SRL:  base_res = operand_a >> shamt;
            OP_SRA:  base_res = WIDTH'($signed(operand_a) >>> shamt);
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}},
                                 $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            OP_XOR:  base_res = operand_a ^ operand_b;
            OP_OR:   base_res = operand_a | operand_b;
            OP_AND:  base_res = operand_a & operand_b;
            default: base_res = operand_a;
        endcase
    end

    // Pick which result lands in the output register and when
    always_comb begin
        fin_res  = md_res;
        fin_load = md_done &&
                   (state_q == ST_MUL || state_q == ST_DIV);
        if (state_q == ST_IDLE) begin
            fin_res  = operation[4] ? md_special_res : base_res;
            fin_load = in_valid && (!operation[4] || md_special);
        end
    end

    // Control FSM with registered result, zero flag and out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            if (fin_load) begin
                result_q    <= fin_res;
                zero_q      <= (fin_res == '0);
                out_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fin_load)
                        state_q <= ST_DONE;
                    else if (md_start)
                        state_q <= operation[2] ? ST_DIV : ST_MUL;
                end
                ST_MUL, ST_DIV: begin
                    if (md_done)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk           (clk),
        .rst           (rst),
        .start_i       (md_start),
        .op_i          (operation[2:0]),
        .a_i           (operand_a),
        .b_i           (operand_b),
        .special_o     (md_special),
        .special_res_o (md_special_res),
        .done_o        (md_done),
        .res_o         (md_res)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH 32 and 16 against a latency/arithmetic model.
// Directed literal cases plus randomized ops with random backpressure.
module tb_seq_alu;

    localparam logic [4:0] ADD   = 5'h00;
    localparam logic [4:0] SUB   = 5'h08;
    localparam logic [4:0] SRA   = 5'h0D;
    localparam logic [4:0] SLT   = 5'h02;
    localparam logic [4:0] SLTU  = 5'h03;
    localparam logic [4:0] MUL   = 5'h10;
    localparam logic [4:0] MULH  = 5'h11;
    localparam logic [4:0] MULHU = 5'h13;
    localparam logic [4:0] DIV   = 5'h14;
    localparam logic [4:0] DIVU  = 5'h15;
    localparam logic [4:0] REM   = 5'h16;
    localparam logic [4:0] REMU  = 5'h17;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2];
    logic        ordy[2];
    logic [4:0]  opc[2];
    logic [31:0] opa[2];
    logic [31:0] opb[2];
    logic        rdy32, rdy16, ov32, ov16, zr32, zr16;
    logic [31:0] res32;
    logic [15:0] res16;

    logic        m_valid[2] = '{1'b0, 1'b0};
    int          m_wait[2]  = '{0, 0};
    logic [31:0] m_res[2]   = '{32'd0, 32'd0};
    bit          chk_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(rdy32),
        .operand_a(opa[0]), .operand_b(opb[0]),
        .operation(opc[0]),
        .out_valid(ov32), .out_ready(ordy[0]),
        .result(res32), .zero(zr32)
    );

    seq_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(rdy16),
        .operand_a(opa[1][15:0]), .operand_b(opb[1][15:0]),
        .operation(opc[1]),
        .out_valid(ov16), .out_ready(ordy[1]),
        .result(res16), .zero(zr16)
    );

    function automatic int wid(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 0) ? ov32 : ov16;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy32 : rdy16;
    endfunction

    function automatic logic get_zr(input int d);
        return (d == 0) ? zr32 : zr16;
    endfunction

    function automatic logic [31:0] get_res(input int d);
        return (d == 0) ? res32 : {16'h0, res16};
    endfunction

    function automatic bit m_idle(input int d);
        return !m_valid[d] && (m_wait[d] == 0);
    endfunction

    // Arithmetic reference computed with 64-bit integers
    function automatic logic [31:0] ref_alu(input int w, input logic [4:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint mask, ua, ub, sa, sb, r, minv;
        int sh;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(x) & mask;
        ub   = longint'(y) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        minv = longint'(1) << (w - 1);
        sh   = int'(ub) & (w - 1);
        r    = 0;
        if (!o[4]) begin
            case (o[3:0])
                4'd0:    r = ua + ub;
                4'd8:    r = ua - ub;
                4'd1:    r = ua << sh;
                4'd5:    r = ua >> sh;
                4'd13:   r = sa >>> sh;
                4'd2:    r = (sa < sb) ? 1 : 0;
                4'd3:    r = (ua < ub) ? 1 : 0;
                4'd4:    r = ua ^ ub;
                4'd6:    r = ua | ub;
                4'd7:    r = ua & ub;
                default: r = ua;
            endcase
        end else begin
            case (o[2:0])
                3'd0: r = ua * ub;
                3'd1: r = (sa * sb) >>> w;
                3'd2: r = (sa * ub) >>> w;
                3'd3: r = (ua * ub) >> w;
                3'd4: r = (ub == 0) ? mask :
                          (ua == minv && sb == -1) ? minv : sa / sb;
                3'd5: r = (ub == 0) ? mask : ua / ub;
                3'd6: r = (ub == 0) ? ua :
                          (ua == minv && sb == -1) ? 0 : sa % sb;
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return 32'(r & mask);
    endfunction

    // True when the op iterates (M op that is not a divide special case)
    function automatic bit slow_op(input int w, input logic [4:0] o,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        longint mask, ua, ub;
        bit spec;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(x) & mask;
        ub   = longint'(y) & mask;
        spec = o[2] && (ub == 0 ||
               (!o[0] && ua == (longint'(1) << (w - 1)) && ub == mask));
        return o[4] && !spec;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Timing model: accept when idle, result after 1 or WIDTH+1 edges
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] <= 1'b0;
                m_wait[d]  <= 0;
                m_res[d]   <= '0;
            end else if (m_valid[d]) begin
                if (ordy[d])
                    m_valid[d] <= 1'b0;
            end else if (m_wait[d] > 0) begin
                m_wait[d] <= m_wait[d] - 1;
                if (m_wait[d] == 1)
                    m_valid[d] <= 1'b1;
            end else if (iv[d]) begin
                m_res[d] <= ref_alu(wid(d), opc[d], opa[d], opb[d]);
                if (slow_op(wid(d), opc[d], opa[d], opb[d]))
                    m_wait[d] <= wid(d);
                else
                    m_valid[d] <= 1'b1;
            end
        end
    end

    // Compare both DUTs against the model every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready_w%0d", wid(d)),
                    32'(get_rdy(d)), 32'(m_idle(d)));
                chk($sformatf("out_valid_w%0d", wid(d)),
                    32'(get_ov(d)), 32'(m_valid[d]));
                if (m_valid[d]) begin
                    chk($sformatf("result_w%0d", wid(d)),
                        get_res(d), m_res[d]);
                    chk($sformatf("zero_w%0d", wid(d)),
                        32'(get_zr(d)), 32'(m_res[d] == 0));
                end
            end
        end
    end

    task automatic run_op(input int d, input logic [4:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input bit has_exp, input logic [31:0] exp,
                          input string nm, input bit bp);
        int w, lat, bud, exp_lat;
        w   = wid(d);
        bud = 0;
        while (!m_idle(d) && bud < 200) begin
            @(posedge clk);
            #1;
            bud++;
        end
        chk({"idle_wait_", nm}, 32'(bud < 200), 32'd1);
        iv[d]   = 1'b1;
        opc[d]  = o;
        opa[d]  = x;
        opb[d]  = y;
        exp_lat = slow_op(w, o, x, y) ? w + 1 : 1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_ov(d) && lat < 100);
        chk({"latency_", nm}, 32'(lat), 32'(exp_lat));
        if (has_exp) begin
            chk({"res_", nm}, get_res(d), exp);
            chk({"zero_", nm}, 32'(get_zr(d)), 32'(exp == 0));
        end
        if (bp) begin
            ordy[d] = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ordy[d] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'd1 << (w - 1);
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst  = 1'b0;
        iv   = '{1'b0, 1'b0};
        ordy = '{1'b1, 1'b1};
        opc  = '{5'd0, 5'd0};
        opa  = '{32'd0, 32'd0};
        opb  = '{32'd0, 32'd0};
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_result", res32, 32'd0);
        chk("reset_zero", 32'(zr32), 32'd0);
        chk("reset_in_ready", 32'(rdy32), 32'd1);
        chk("reset_out_valid", 32'(ov32), 32'd0);
        chk("reset_result16", {16'h0, res16}, 32'd0);
        chk_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        chk("model_mulhu", ref_alu(32, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            32'hFFFF_FFFE);
        chk("model_mulh", ref_alu(32, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            32'h0);
        chk("model_div", ref_alu(32, DIV, 32'hFFFF_FFF9, 32'd2),
            32'hFFFF_FFFD);
        chk("model_rem", ref_alu(32, REM, 32'hFFFF_FFF9, 32'd2),
            32'hFFFF_FFFF);
        chk("model_sra", ref_alu(32, SRA, 32'h8000_0000, 32'd1),
            32'hC000_0000);

        run_op(0, ADD, 32'd5, 32'd3, 1, 32'd8, "add", 0);
        run_op(0, SUB, 32'd5, 32'd3, 1, 32'd2, "sub", 0);
        run_op(0, SRA, 32'h8000_0000, 32'd1, 1, 32'hC000_0000, "sra", 0);
        run_op(0, SLT, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, "slt", 0);
        run_op(0, SLTU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, "sltu", 0);
        run_op(0, SUB, 32'd7, 32'd7, 1, 32'd0, "sub_zero", 0);
        run_op(0, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, "mulh", 0);
        run_op(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE,
               "mulhu", 0);
        run_op(0, MUL, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, "mul", 0);
        run_op(0, DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, "div", 0);
        run_op(0, REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, "rem", 0);
        run_op(0, DIVU, 32'd1234, 32'd0, 1, 32'hFFFF_FFFF, "divu_z", 0);
        run_op(0, REMU, 32'd9, 32'd0, 1, 32'd9, "remu_z", 0);
        run_op(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000,
               "div_ovf", 0);
        run_op(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,
               "rem_ovf", 0);

        ordy[0] = 1'b0;
        run_op(0, DIVU, 32'd100, 32'd7, 1, 32'd14, "divu_bp", 0);
        iv[0]  = 1'b1;
        opc[0] = ADD;
        opa[0] = 32'd1;
        opb[0] = 32'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_result", res32, 32'd14);
            chk("bp_hold_in_ready", 32'(rdy32), 32'd0);
            chk("bp_hold_out_valid", 32'(ov32), 32'd1);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(rdy32), 32'd1);
        chk("bp_release_out_valid", 32'(ov32), 32'd0);
        run_op(0, ADD, 32'd2, 32'd2, 1, 32'd4, "add_after_bp", 0);

        iv[0]  = 1'b1;
        opc[0] = MUL;
        opa[0] = 32'd12345;
        opb[0] = 32'd678;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(rdy32), 32'd1);
        chk("abort_out_valid", 32'(ov32), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(ov32), 32'd0);
        end
        @(posedge clk);
        #1;
        run_op(0, ADD, 32'd10, 32'd20, 1, 32'd30, "add_after_rst", 0);

        run_op(1, ADD, 32'd5, 32'd3, 1, 32'd8, "w16_add", 0);
        run_op(1, SUB, 32'd7, 32'd7, 1, 32'd0, "w16_sub_zero", 0);
        run_op(1, SRA, 32'h8000, 32'd1, 1, 32'hC000, "w16_sra", 0);
        run_op(1, MULHU, 32'hFFFF, 32'hFFFF, 1, 32'hFFFE, "w16_mulhu", 0);
        run_op(1, MUL, 32'd7, 32'hFFFD, 1, 32'hFFEB, "w16_mul", 0);
        run_op(1, DIV, 32'hFFF9, 32'd2, 1, 32'hFFFD, "w16_div", 0);
        run_op(1, REM, 32'hFFF9, 32'd2, 1, 32'hFFFF, "w16_rem", 0);
        run_op(1, DIVU, 32'd5, 32'd0, 1, 32'hFFFF, "w16_divu_z", 0);
        run_op(1, DIV, 32'h8000, 32'hFFFF, 1, 32'h8000, "w16_div_ovf", 0);

        for (int i = 0; i < 80; i++) begin
            int d;
            d = $urandom_range(0, 1);
            run_op(d, 5'($urandom_range(0, 31)),
                   rnd_operand(wid(d)), rnd_operand(wid(d)),
                   0, 32'd0, "rnd", 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
